// File: rtl/uart_rx_ctrl.sv
// Read sequencer and FWFT receive buffer for the UART receiver: strobes rdn on each
// new data_ready, latches the byte bus, queues it, and flags overruns and idle gaps.
module uart_rx_ctrl #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned RD_SETUP = 2,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned TO_W     = 16
) (
  input  logic              clk_sample,
  input  logic              rst,
  input  logic              enable,
  input  logic              data_ready,
  input  logic [7:0]        din,
  output logic              rdn,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_cnt,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic              idle_to
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [3:0]        SetupLast = 4'(RD_SETUP - 1);
  localparam logic [TO_W-1:0]   ToMax     = TO_W'(TIMEOUT);
  localparam logic [ADDR_W:0]   CntFull   = (ADDR_W + 1)'(Depth);

  typedef enum logic [4:0] {
    StIdle    = 5'b00001,
    StRead    = 5'b00010,
    StCapture = 5'b00100,
    StPush    = 5'b01000,
    StWaitLow = 5'b10000
  } state_e;

  state_e            state_q, state_d;
  logic              dr_q;
  logic [3:0]        setup_q, setup_d;
  logic              rdn_q, rdn_d;
  logic [7:0]        cap_q, cap_d;
  logic [7:0]        mem [Depth];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovr_q;
  logic [TO_W-1:0]   idle_cnt_q;
  logic              armed_q;

  logic rise, push_req, do_pop, do_push, ovr_set;

  assign rise = data_ready & ~dr_q;

  always_comb begin
    state_d = state_q;
    setup_d = setup_q;
    rdn_d   = rdn_q;
    cap_d   = cap_q;
    unique case (state_q)
      StIdle: begin
        if (rise && enable) begin
          state_d = StRead;
          rdn_d   = 1'b0;
          setup_d = 4'd0;
        end
      end
      StRead: begin
        if (setup_q == SetupLast) begin
          state_d = StCapture;
        end else begin
          setup_d = setup_q + 4'd1;
        end
      end
      StCapture: begin
        cap_d   = din;
        rdn_d   = 1'b1;
        state_d = StPush;
      end
      StPush: state_d = StWaitLow;
      StWaitLow: begin
        if (!data_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        rdn_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      dr_q    <= 1'b0;
      setup_q <= 4'd0;
      rdn_q   <= 1'b1;
      cap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      dr_q    <= data_ready;
      setup_q <= setup_d;
      rdn_q   <= rdn_d;
      cap_q   <= cap_d;
    end
  end

  // A full FIFO still accepts the push when the host pops in the same cycle.
  assign push_req = (state_q == StPush);
  assign do_pop   = rd_en & ~fifo_empty;
  assign do_push  = push_req & (~fifo_full | do_pop);
  assign ovr_set  = push_req & fifo_full & ~do_pop;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_sample) begin
    if (do_push) mem[wptr_q] <= cap_q;
  end

  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (clr_overrun) begin
        ovr_q <= 1'b0;
      end
    end
  end

  // Timer is armed by any push (stored or dropped) and disarms after one pulse.
  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      idle_cnt_q <= '0;
      armed_q    <= 1'b0;
    end else if (push_req) begin
      idle_cnt_q <= '0;
      armed_q    <= 1'b1;
    end else if (armed_q) begin
      if (idle_cnt_q == ToMax) begin
        armed_q <= 1'b0;
      end else begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
    end
  end

  assign rdn        = rdn_q;
  assign fifo_cnt   = cnt_q;
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CntFull);
  assign rd_data    = fifo_empty ? 8'd0 : mem[rptr_q];
  assign overrun    = ovr_q;
  assign idle_to    = armed_q & (idle_cnt_q == ToMax);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a receiver model drives din while rdn is low and a
// scoreboard queue holds the bytes the host should pop, in order.
module tb_uart_rx_ctrl;

  localparam int Timeout = 1000;

  logic       clk_sample = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] din;
  logic       rdn;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic [3:0] fifo_cnt;
  logic       overrun;
  logic       clr_overrun = 1'b0;
  logic       idle_to;

  logic [7:0] rx_byte = 8'h00;
  logic [7:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rdn_low = 0;
  int to_count = 0;
  int to_last = -1;
  int last_vis = 0;
  int v1;

  assign din = rdn ? 8'hEE : rx_byte;

  uart_rx_ctrl #(
    .ADDR_W(3), .RD_SETUP(2), .TIMEOUT(Timeout), .TO_W(16)
  ) dut (
    .clk_sample (clk_sample),
    .rst        (rst),
    .enable     (enable),
    .data_ready (data_ready),
    .din        (din),
    .rdn        (rdn),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_cnt   (fifo_cnt),
    .overrun    (overrun),
    .clr_overrun(clr_overrun),
    .idle_to    (idle_to)
  );

  always #5 clk_sample = ~clk_sample;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sample);
    #1;
    cyc++;
    if (!rdn) rdn_low++;
    if (idle_to) begin
      to_count++;
      to_last = cyc;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed pop request expected scoreboard entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_nonempty"}, int'(fifo_empty), 0);
      check(tag, int'(rd_data), int'(e));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
  endtask

  // One 32-cycle data_ready pulse; optionally pops during PUSH or drops enable during READ.
  task automatic send_byte(input logic [7:0] b, input bit pop_at_push, input bit drop_en);
    rx_byte = b;
    data_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (pop_at_push && i == 4) begin
        check("push_pop_head", int'(rd_data), int'(sb.pop_front()));
        rd_en = 1'b1;
      end
      tick();
      rd_en = 1'b0;
      if (drop_en && i == 0) enable = 1'b0;
      if (i == 4) last_vis = cyc;
    end
    data_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    tick();
    check("rst_rdn", int'(rdn), 1);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_full", int'(fifo_full), 0);
    check("rst_cnt", int'(fifo_cnt), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_idle_to", int'(idle_to), 0);
    rst = 1'b1;
    tick();
    tick();

    // Single byte with exact latency
    rdn_low = 0;
    rx_byte = 8'hA5;
    data_ready = 1'b1;
    sb.push_back(8'hA5);
    tick();
    check("t1_rdn_low", int'(rdn), 0);
    tick();
    tick();
    tick();
    check("t1_rdn_release", int'(rdn), 1);
    check("t1_not_early", int'(fifo_empty), 1);
    tick();
    v1 = cyc;
    check("t1_visible", int'(fifo_empty), 0);
    check("t1_cnt", int'(fifo_cnt), 1);
    check("t1_head", int'(rd_data), int'(sb[0]));
    for (int i = 0; i < 27; i++) tick();
    data_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t1_rdn_cycles", rdn_low, 3);
    check("t1_one_capture", int'(fifo_cnt), 1);
    pop_check("t1_pop");

    // Idle timeout fires once, then re-arms on the next byte
    for (int i = 0; i < Timeout + 20; i++) tick();
    check("t4_pulses1", to_count, 1);
    check("t4_when1", to_last, v1 + Timeout);
    sb.push_back(8'hB7);
    send_byte(8'hB7, 1'b0, 1'b0);
    pop_check("t4_pop");
    for (int i = 0; i < Timeout + 20; i++) tick();
    check("t4_pulses2", to_count, 2);
    check("t4_when2", to_last, last_vis + Timeout);

    // Overflow: ten bytes into eight slots
    for (int i = 0; i < 10; i++) begin
      if (i < 8) sb.push_back(8'(i));
      send_byte(8'(i), 1'b0, 1'b0);
    end
    check("t2_cnt", int'(fifo_cnt), 8);
    check("t2_full", int'(fifo_full), 1);
    check("t2_overrun", int'(overrun), 1);
    check("t2_head", int'(rd_data), 0);
    for (int i = 0; i < 8; i++) pop_check("t2_pop");
    check("t2_empty", int'(fifo_empty), 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t2_pop_empty_cnt", int'(fifo_cnt), 0);
    check("t2_overrun_held", int'(overrun), 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("t2_overrun_clr", int'(overrun), 0);

    // Full FIFO with a pop in the PUSH cycle
    for (int i = 0; i < 8; i++) begin
      sb.push_back(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    end
    send_byte(8'h18, 1'b1, 1'b0);
    sb.push_back(8'h18);
    check("t3_cnt", int'(fifo_cnt), 8);
    check("t3_no_overrun", int'(overrun), 0);
    for (int i = 0; i < 8; i++) pop_check("t3_pop");

    // Enable gating
    rdn_low = 0;
    enable = 1'b0;
    send_byte(8'h55, 1'b0, 1'b0);
    check("t5_rdn_idle", rdn_low, 0);
    check("t5_cnt", int'(fifo_cnt), 0);
    enable = 1'b1;
    send_byte(8'h66, 1'b0, 1'b1);
    sb.push_back(8'h66);
    check("t5_drop_en_cnt", int'(fifo_cnt), 1);
    pop_check("t5_pop");
    enable = 1'b1;

    // Asynchronous reset mid-read
    send_byte(8'h70, 1'b0, 1'b0);
    rx_byte = 8'h77;
    data_ready = 1'b1;
    tick();
    tick();
    check("t6_in_read", int'(rdn), 0);
    rst = 1'b0;
    #1;
    check("t6_rdn_async", int'(rdn), 1);
    check("t6_cnt", int'(fifo_cnt), 0);
    data_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    sb.delete();
    sb.push_back(8'h88);
    send_byte(8'h88, 1'b0, 1'b0);
    check("t6_after_cnt", int'(fifo_cnt), 1);
    pop_check("t6_pop");
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
